mac_accum_ctrl: RTL and testbench

Sequencer for one synaptic MAC lane of a neuron unit. It latches the lane's weight table and source-address table, and records which connections spiked during the current timestep. On the timestep-end `clear` pulse it time-multiplexes one shared 32-bit floating-point adder across the recorded spikes and delivers the accumulated weight to the potential adder. It sits between the NoC spike-delivery interface and the external combinational `Addition_Subtraction` instance.

---
 rtl/mac_pkg.sv | 19 +
 rtl/mac_addr_match.sv | 26 ++
 rtl/mac_accum_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_mac_accum_ctrl.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared constants and types for the synaptic MAC lane sequencer.
// Optional build macro used by mac_accum_ctrl: MAC_SKIP_ZERO_EN.
package mac_pkg;

    localparam int NUM_CONN = 5;
    localparam int ADDR_W   = 12;
    localparam int W_W      = 32;

    // IEEE-754 single-precision +0.0, the accumulator start value.
    localparam logic [31:0] FP_ZERO = 32'h0000_0000;

    // Sequencer state, also visible as r_state inside mac_accum_ctrl.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/mac_addr_match.sv
// Combinational match of one spiking source address against the lane's
// address table. Entry 0 sits in the MSBs; the lowest matching index wins.
module mac_addr_match #(
    parameter int NUM_CONN = 5,
    parameter int ADDR_W   = 12,
    parameter int IDX_W    = 3
) (
    input  logic [ADDR_W*NUM_CONN-1:0] addr_table,
    input  logic [ADDR_W-1:0]          source_address,
    output logic                       hit,
    output logic [IDX_W-1:0]           idx
);

    // Scan from the highest entry down so the lowest matching index is kept last.
    always_comb begin
        hit = 1'b0;
        idx = '0;
        for (int k = NUM_CONN - 1; k >= 0; k--) begin
            if (addr_table[ADDR_W*(NUM_CONN-k)-1 -: ADDR_W] == source_address) begin
                hit = 1'b1;
                idx = IDX_W'(k);
            end
        end
    end

endmodule

// File: rtl/mac_accum_ctrl.sv
// Sequencer for one synaptic MAC lane: latches weight/address tables,
// records spiking connections per timestep, and on the timestep-end clear
// drives an external combinational FP adder across the recorded spikes.
// Build macro: MAC_SKIP_ZERO_EN -- when defined, ACCUM visits only the
// set bits of the snapshot instead of walking every connection.
//
// Handshake: there is no back-pressure. acc_valid is a one-cycle pulse that
// qualifies mult_output and acc_exception; mult_output holds until the next
// pulse. spike_miss is a one-cycle pulse per unmatched spike.
module mac_accum_ctrl #(
    parameter int NUM_CONN = mac_pkg::NUM_CONN,
    parameter int ADDR_W   = mac_pkg::ADDR_W,
    parameter int W_W      = mac_pkg::W_W
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic                       cfg_load,
    input  logic [W_W*NUM_CONN-1:0]    weights_array,
    input  logic [ADDR_W*NUM_CONN-1:0] source_addresses_array,
    input  logic                       spike_valid,
    input  logic [ADDR_W-1:0]          source_address,
    input  logic                       clear,
    output logic [W_W-1:0]             add_a,
    output logic [W_W-1:0]             add_b,
    input  logic [W_W-1:0]             add_sum,
    input  logic                       add_exception,
    output logic [W_W-1:0]             mult_output,
    output logic                       acc_valid,
    output logic                       acc_exception,
    output logic                       busy,
    output logic                       spike_miss,
    output logic                       overrun
);
    import mac_pkg::*;

    localparam int IDX_W = (NUM_CONN > 1) ? $clog2(NUM_CONN) : 1;

    state_t              r_state;
    logic [W_W-1:0]      r_weights [NUM_CONN];
    logic [W_W-1:0]      r_wshadow [NUM_CONN];
    logic [ADDR_W*NUM_CONN-1:0] r_addrs;
    logic [NUM_CONN-1:0] r_incoming;
    logic [NUM_CONN-1:0] r_snap;
    logic [W_W-1:0]      r_acc;
    logic [IDX_W-1:0]    r_idx;
    logic                r_exc;
    logic [W_W-1:0]      r_mult_output;
    logic                r_acc_valid;
    logic                r_acc_exception;
    logic                r_spike_miss;
    logic                r_overrun;

    logic                w_hit;
    logic [IDX_W-1:0]    w_hit_idx;
    logic [NUM_CONN-1:0] w_hitvec;
    logic [NUM_CONN-1:0] w_snap_next;
    logic [IDX_W-1:0]    w_start_idx;
    logic                w_last;
    logic [IDX_W-1:0]    w_next_idx;

    mac_addr_match #(
        .NUM_CONN (NUM_CONN),
        .ADDR_W   (ADDR_W),
        .IDX_W    (IDX_W)
    ) u_match (
        .addr_table     (r_addrs),
        .source_address (source_address),
        .hit            (w_hit),
        .idx            (w_hit_idx)
    );

    // One-hot of this cycle's hit, folded into the snapshot so a spike
    // coincident with clear belongs to the ending timestep.
    always_comb begin
        w_hitvec = '0;
        if (spike_valid && w_hit) begin
            w_hitvec[w_hit_idx] = 1'b1;
        end
        w_snap_next = r_incoming | w_hitvec;
    end

`ifdef MAC_SKIP_ZERO_EN
    // Priority encoders: first set bit of the new snapshot, and the next set
    // bit above the current index; an empty remainder ends the pass.
    always_comb begin
        w_start_idx = '0;
        for (int k = NUM_CONN - 1; k >= 0; k--) begin
            if (w_snap_next[k]) begin
                w_start_idx = IDX_W'(k);
            end
        end
        w_last     = 1'b1;
        w_next_idx = r_idx;
        for (int k = NUM_CONN - 1; k >= 0; k--) begin
            if (r_snap[k] && (k > int'(r_idx))) begin
                w_last     = 1'b0;
                w_next_idx = IDX_W'(k);
            end
        end
    end
`else
    // Fixed walk over every connection in ascending order.
    always_comb begin
        w_start_idx = '0;
        w_last      = (r_idx == IDX_W'(NUM_CONN - 1));
        w_next_idx  = r_idx + IDX_W'(1);
    end
`endif

    // Table registers; loads are accepted in any state.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_addrs <= '0;
            for (int k = 0; k < NUM_CONN; k++) begin
                r_weights[k] <= '0;
            end
        end else if (cfg_load) begin
            r_addrs <= source_addresses_array;
            for (int k = 0; k < NUM_CONN; k++) begin
                r_weights[k] <= weights_array[W_W*(NUM_CONN-k)-1 -: W_W];
            end
        end
    end

    // Spike capture plus the IDLE/ACCUM/DONE sequencer with registered outputs.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state         <= IDLE;
            r_incoming      <= '0;
            r_snap          <= '0;
            r_acc           <= FP_ZERO;
            r_idx           <= '0;
            r_exc           <= 1'b0;
            r_mult_output   <= '0;
            r_acc_valid     <= 1'b0;
            r_acc_exception <= 1'b0;
            r_spike_miss    <= 1'b0;
            r_overrun       <= 1'b0;
            for (int k = 0; k < NUM_CONN; k++) begin
                r_wshadow[k] <= '0;
            end
        end else begin
            r_acc_valid  <= 1'b0;
            r_spike_miss <= spike_valid && !w_hit;
            r_incoming   <= w_snap_next;
            case (r_state)
                IDLE: begin
                    if (clear) begin
                        r_snap     <= w_snap_next;
                        r_incoming <= '0;
                        r_acc      <= FP_ZERO;
                        r_idx      <= w_start_idx;
                        r_exc      <= 1'b0;
                        for (int k = 0; k < NUM_CONN; k++) begin
                            r_wshadow[k] <= r_weights[k];
                        end
                        r_state    <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (clear) begin
                        r_overrun <= 1'b1;
                    end
                    if (r_snap[r_idx]) begin
                        r_acc <= add_sum;
                        r_exc <= r_exc | add_exception;
                    end
                    if (w_last) begin
                        r_state <= DONE;
                    end else begin
                        r_idx <= w_next_idx;
                    end
                end
                DONE: begin
                    if (clear) begin
                        r_overrun <= 1'b1;
                    end
                    r_mult_output   <= r_acc;
                    r_acc_valid     <= 1'b1;
                    r_acc_exception <= r_exc;
                    r_state         <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Adder operands are only presented while accumulating.
    always_comb begin
        add_a = '0;
        add_b = '0;
        if (r_state == ACCUM) begin
            add_a = r_acc;
            add_b = r_wshadow[r_idx];
        end
    end

    assign busy          = (r_state != IDLE);
    assign mult_output   = r_mult_output;
    assign acc_valid     = r_acc_valid;
    assign acc_exception = r_acc_exception;
    assign spike_miss    = r_spike_miss;
    assign overrun       = r_overrun;

endmodule

// File: tb/tb_mac_accum_ctrl.sv
// Self-checking bench for mac_accum_ctrl with a behavioural FP adder.
// Honours MAC_SKIP_ZERO_EN for the expected latency only.
module tb_mac_accum_ctrl;

    localparam int NC = 5;
    localparam int AW = 12;
    localparam int WW = 32;

    logic              CLK = 1'b0;
    logic              RESET = 1'b1;
    logic              cfg_load = 1'b0;
    logic [WW*NC-1:0]  weights_array = '0;
    logic [AW*NC-1:0]  source_addresses_array = '0;
    logic              spike_valid = 1'b0;
    logic [AW-1:0]     source_address = '0;
    logic              clear = 1'b0;
    logic [WW-1:0]     add_a, add_b, add_sum;
    logic              add_exception;
    logic [WW-1:0]     mult_output;
    logic              acc_valid, acc_exception, busy, spike_miss, overrun;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int miss_cnt = 0;

    // Scoreboard: {acc_exception, mult_output}, clear cycle, expected latency.
    logic [32:0] exp_q[$];
    int          start_q[$];
    int          lat_q[$];

    mac_accum_ctrl dut (
        .CLK                    (CLK),
        .RESET                  (RESET),
        .cfg_load               (cfg_load),
        .weights_array          (weights_array),
        .source_addresses_array (source_addresses_array),
        .spike_valid            (spike_valid),
        .source_address         (source_address),
        .clear                  (clear),
        .add_a                  (add_a),
        .add_b                  (add_b),
        .add_sum                (add_sum),
        .add_exception          (add_exception),
        .mult_output            (mult_output),
        .acc_valid              (acc_valid),
        .acc_exception          (acc_exception),
        .busy                   (busy),
        .spike_miss             (spike_miss),
        .overrun                (overrun)
    );

    // ---------------- clock / reset ----------------
    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    // ---------------- behavioural FP adder (normal values only) ----------------
    function automatic real sp2r(input logic [31:0] b);
        logic [63:0] d;
        if (b[30:0] == 31'd0) return 0.0;
        d = {b[31], {3'b000, b[30:23]} + 11'd896, b[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2sp(input real r);
        logic [63:0] d;
        logic [10:0] e;
        d = $realtobits(r);
        if (d[62:0] == 63'd0) return 32'h0000_0000;
        e = d[62:52] - 11'd896;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    // Synthetic exception: raised whenever the negative weight is presented.
    always_comb begin
        add_sum       = r2sp(sp2r(add_a) + sp2r(add_b));
        add_exception = (add_b == 32'hBF80_0000);
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int lat_for(input int pop);
`ifdef MAC_SKIP_ZERO_EN
        return (pop == 0) ? 3 : pop + 2;
`else
        return NC + 2;
`endif
    endfunction

    // ---------------- monitor ----------------
    always @(negedge CLK) begin
        logic [32:0] e;
        int s, l;
        if (spike_miss) miss_cnt++;
        if (!RESET && acc_valid) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_acc_valid: got mult_output %h with no result expected", mult_output);
            end else begin
                e = exp_q.pop_front();
                s = start_q.pop_front();
                l = lat_q.pop_front();
                check("mult_output", 64'(mult_output), 64'(e[31:0]));
                check("acc_exception", 64'(acc_exception), 64'(e[32]));
                check("latency", 64'(cyc - s + 1), 64'(l));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic load_cfg();
        weights_array = {32'h3F80_0000, 32'h4000_0000, 32'h3F00_0000, 32'h4080_0000, 32'hBF80_0000};
        source_addresses_array = {12'h001, 12'h002, 12'h003, 12'h004, 12'h005};
        cfg_load = 1'b1;
        tick();
        cfg_load = 1'b0;
    endtask

    task automatic send_spike(input logic [AW-1:0] a);
        spike_valid    = 1'b1;
        source_address = a;
        tick();
        spike_valid    = 1'b0;
    endtask

    // Pulse clear (optionally with a coincident spike) and queue the expectation.
    task automatic do_clear(input logic [31:0] val, input logic exc, input int pop,
                            input logic with_spike, input logic [AW-1:0] a);
        exp_q.push_back({exc, val});
        lat_q.push_back(lat_for(pop));
        clear          = 1'b1;
        spike_valid    = with_spike;
        source_address = a;
        tick();
        start_q.push_back(cyc);
        clear          = 1'b0;
        spike_valid    = 1'b0;
    endtask

    task automatic wait_done();
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (exp_q.size() == 0 && !busy) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) begin
            n_tests++;
            n_fail++;
            $display("FAIL timeout: %0d results still pending, busy %0b", exp_q.size(), busy);
            exp_q.delete();
            start_q.delete();
            lat_q.delete();
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        tick();
        tick();
        check("reset_mult_output", 64'(mult_output), 64'h0);
        check("reset_acc_valid", 64'(acc_valid), 64'h0);
        check("reset_busy", 64'(busy), 64'h0);
        check("reset_add_a", 64'(add_a), 64'h0);
        check("reset_add_b", 64'(add_b), 64'h0);
        check("reset_overrun", 64'(overrun), 64'h0);
        check("reset_spike_miss", 64'(spike_miss), 64'h0);
        RESET = 1'b0;
        tick();
        load_cfg();

        // 1: connections 0 and 2 -> 1.0 + 0.5 = 1.5
        send_spike(12'h001);
        send_spike(12'h003);
        do_clear(32'h3FC0_0000, 1'b0, 2, 1'b0, '0);
        check("busy_after_clear", 64'(busy), 64'h1);
        wait_done();

        // 2: all five, 0x002 three times -> 1+2+0.5+4-1 = 6.5 (0x40D00000)
        send_spike(12'h001);
        send_spike(12'h002);
        send_spike(12'h002);
        send_spike(12'h003);
        send_spike(12'h002);
        send_spike(12'h004);
        send_spike(12'h005);
        do_clear(32'h40D0_0000, 1'b1, 5, 1'b0, '0);
        wait_done();

        // 3: unmatched address only -> miss pulse, empty result still delivered
        send_spike(12'h0FF);
        check("spike_miss_pulse", 64'(spike_miss), 64'h1);
        tick();
        check("spike_miss_single", 64'(spike_miss), 64'h0);
        do_clear(32'h0000_0000, 1'b0, 0, 1'b0, '0);
        wait_done();

        // 4: spike coincident with clear belongs to this timestep,
        //    spike during ACCUM belongs to the next one
        do_clear(32'h4080_0000, 1'b0, 1, 1'b1, 12'h004);
        send_spike(12'h002);
        wait_done();
        do_clear(32'h4000_0000, 1'b0, 1, 1'b0, '0);
        wait_done();

        // 5: second clear three cycles after the first while still busy
        check("overrun_before", 64'(overrun), 64'h0);
        send_spike(12'h001);
        send_spike(12'h003);
        do_clear(32'h3FC0_0000, 1'b0, 2, 1'b0, '0);
        tick();
        tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("overrun_set", 64'(overrun), 64'h1);
        wait_done();
        for (int i = 0; i < 8; i++) tick();
        check("overrun_sticky", 64'(overrun), 64'h1);

        // 6: reset mid-ACCUM aborts the pass with no acc_valid
        send_spike(12'h001);
        send_spike(12'h002);
        do_clear(32'h4040_0000, 1'b0, 2, 1'b0, '0);
        tick();
        RESET = 1'b1;
        #1;
        exp_q.delete();
        start_q.delete();
        lat_q.delete();
        check("midreset_mult_output", 64'(mult_output), 64'h0);
        check("midreset_busy", 64'(busy), 64'h0);
        check("midreset_add_a", 64'(add_a), 64'h0);
        check("midreset_add_b", 64'(add_b), 64'h0);
        check("midreset_overrun", 64'(overrun), 64'h0);
        for (int i = 0; i < 3; i++) tick();
        RESET = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        check("no_valid_after_reset", 64'(mult_output), 64'h0);
        load_cfg();
        send_spike(12'h005);
        do_clear(32'hBF80_0000, 1'b1, 1, 1'b0, '0);
        wait_done();

        check("spike_miss_total", 64'(miss_cnt), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Hard wall-clock bound in case the stimulus itself stalls.
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "global timeout");
    end

endmodule
